// File: rtl/uu_acmac_tx_mem_reader.sv
// rtl/uu_acmac_tx_mem_reader.sv - TX frame memory read initiator streaming bytes through a credit-controlled FIFO
//
// Fetches a wrap-around byte range from the TX frame memory and presents it on a
// valid/ready byte stream. The one-cycle registered read latency is hidden by a
// small output FIFO; reads are only issued while credits remain.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, base_addr, len command strobe (IDLE only), first address, byte count
//   abort                 cancel current transfer (priority over start)
//   busy, done, err       status: transfer active, completion pulse, reject pulse
//   mem_tx_in_*           memory request side (read only: wen and write data tied 0)
//   mem_tx_out_data       registered read data, valid the cycle after an enable
//   out_data/valid/last   byte stream to the consumer, out_ready handshake
module uu_acmac_tx_mem_reader #(
   parameter int ADDR_W     = 8,
   parameter int MEM_DEPTH  = 208,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_tx_in_en,
   output logic              mem_tx_in_wen,
   output logic [ADDR_W-1:0] mem_tx_in_addr,
   output logic [7:0]        mem_tx_in_data,
   input  logic [7:0]        mem_tx_out_data,
   output logic [7:0]        out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_t;

   state_t                  state;
   logic [ADDR_W-1:0]       addr_q;
   logic [LEN_W-1:0]        remaining_q;
   logic                    inflight_q;
   logic                    inflight_last_q;
   logic [7:0]              fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   fifo_last;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;

   logic                    pop;
   logic                    push;
   logic                    issue;
   logic                    cmd_bad;
   logic [OCC_W-1:0]        occupancy;

   always_comb begin
      pop       = (count != '0) && out_ready;
      push      = inflight_q;
      // Credits: bytes held plus the read in flight, less the byte leaving this cycle.
      occupancy = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
      issue     = (state == ST_FETCH) && !abort && (occupancy < OCC_W'(FIFO_DEPTH));
      cmd_bad   = (32'(len) > 32'(MEM_DEPTH)) || (32'(base_addr) >= 32'(MEM_DEPTH));
   end

   assign mem_tx_in_en   = issue;
   assign mem_tx_in_wen  = 1'b0;
   assign mem_tx_in_addr = addr_q;
   assign mem_tx_in_data = 8'h00;

   assign out_valid = (count != '0);
   assign out_data  = fifo_data[rd_ptr];
   assign out_last  = out_valid && fifo_last[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         addr_q          <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_last       <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= 8'h00;
         end
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (abort && (state != ST_IDLE)) begin
            // Flush everything, including a read whose data arrives next cycle.
            state           <= ST_IDLE;
            busy            <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
         end else begin
            if (push) begin
               fifo_data[wr_ptr] <= mem_tx_out_data;
               fifo_last[wr_ptr] <= inflight_last_q;
               wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            inflight_q      <= issue;
            inflight_last_q <= issue && (remaining_q == LEN_W'(1));
            if (issue) begin
               addr_q      <= (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
               remaining_q <= remaining_q - LEN_W'(1);
            end

            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     if (len == '0) begin
                        done <= 1'b1;
                     end else if (cmd_bad) begin
                        err <= 1'b1;
                     end else begin
                        addr_q      <= base_addr;
                        remaining_q <= len;
                        busy        <= 1'b1;
                        state       <= ST_FETCH;
                     end
                  end
               end
               ST_FETCH: begin
                  if (issue && (remaining_q == LEN_W'(1))) begin
                     state <= ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  // The tagged byte is the last one pushed, so its handshake empties the FIFO.
                  if (pop && out_last) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
